// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes, a one-clock
// terminal-count pulse and a busy flag that is high only while counting.
module countdown_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    // Priority is rst > load > en; tc defaults low so it can only pulse for one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
            busy       <= 1'b0;
        end else if (load) begin
            counter    <= load_val;
            reload_reg <= load_val;
            tc         <= 1'b0;
            if (load_val != '0) begin
                state <= RUN;
                busy  <= 1'b1;
            end else begin
                state <= DONE;
                busy  <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
            case (state)
                RUN: begin
                    if (en) begin
                        if (counter == WIDTH'(1)) begin
                            // Terminal edge: auto_reload only matters here.
                            tc <= 1'b1;
                            if (auto_reload) begin
                                counter <= reload_reg;
                            end else begin
                                counter <= '0;
                                state   <= DONE;
                                busy    <= 1'b0;
                            end
                        end else if (counter != '0) begin
                            counter <= counter - WIDTH'(1);
                        end
                    end
                end
                IDLE, DONE: begin
                    counter <= counter;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded bench for countdown_timer: directed scenarios plus random traffic
// against a behavioural model, with a separate monitor comparing every cycle.
module tb_countdown_timer;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] counter;
        logic         tc;
        logic         busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] counter;
    logic         tc;
    logic         busy;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: remaining count, period and whether a countdown is live.
    int m_count = 0;
    int m_period = 0;
    bit m_live = 1'b0;
    bit m_tc = 1'b0;

    countdown_timer #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .load(load),
        .load_val(load_val),
        .auto_reload(auto_reload),
        .counter(counter),
        .tc(tc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit l, input int lv, input bit e, input bit ar);
        m_tc = 1'b0;
        if (r) begin
            m_count = 0; m_period = 0; m_live = 1'b0;
        end else if (l) begin
            m_count = lv; m_period = lv; m_live = (lv != 0);
        end else if (m_live && e) begin
            if (m_count == 1) begin
                m_tc = 1'b1;
                if (ar) m_count = m_period;
                else begin
                    m_count = 0; m_live = 1'b0;
                end
            end else begin
                m_count = m_count - 1;
            end
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input bit r, input bit l, input int lv, input bit e, input bit ar);
        exp_t x;
        @(negedge clk);
        rst = r; load = l; load_val = W'(lv); en = e; auto_reload = ar;
        model_step(r, l, lv, e, ar);
        x.counter = W'(m_count);
        x.tc      = m_tc;
        x.busy    = m_live;
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: the timer presents a result every edge, so pop one entry per edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if ($isunknown({counter, tc, busy})) begin
                    errors++;
                    $display("FAIL unknown_out: got c=%b tc=%b busy=%b", counter, tc, busy);
                end
                check("counter", int'(counter), int'(x.counter));
                check("tc", int'(tc), int'(x.tc));
                check("busy", int'(busy), int'(x.busy));
            end
        end
    end

    initial begin
        int n;
        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 9, 1, 1);
        // One-shot countdown from 5, then 10 quiet cycles at 0
        cyc(0, 1, 5, 1, 0);
        repeat (5) cyc(0, 0, 0, 1, 0);
        repeat (10) cyc(0, 0, 0, 1, 0);
        // Auto-reload with period 3
        cyc(0, 1, 3, 1, 1);
        repeat (6) cyc(0, 0, 0, 1, 1);
        // auto_reload toggled away from terminal edge has no effect; sampled at terminal
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        // Enable gating
        cyc(0, 1, 4, 0, 0);
        cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
        // en ignored in DONE
        repeat (3) cyc(0, 0, 0, 1, 1);
        // Load 9 while counter=2
        cyc(0, 1, 5, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 9, 1, 0);
        // Load 7 on the 1->0 edge
        repeat (8) cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 7, 1, 0);
        cyc(0, 0, 0, 1, 0);
        // Reset mid-run, then en has no effect
        cyc(0, 1, 6, 1, 0);
        cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        repeat (5) cyc(0, 0, 0, 1, 1);
        // Zero load goes straight to DONE without tc
        cyc(0, 1, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 1);
        // Max load: 15 edges to 0 with one tc
        cyc(0, 1, 15, 1, 0);
        repeat (17) cyc(0, 0, 0, 1, 0);
        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                bit'($urandom_range(0, 1)));
        end
        cyc(0, 0, 0, 0, 0);
        // Bounded drain of the scoreboard
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #3;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
